// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: prefetching read stage behind the async FIFO, in the read clock domain.
// Ports: rd_clk, rd_rst (async, active low); fifo_empty, fifo_data, fifo_rd_en (FIFO side);
//   m_valid, m_ready, m_data (stream side); level (words held in the prefetch buffer).
// Optional macro FIFO_RD_STREAM_CNT_EN adds xfer_cnt and stall_cnt outputs.
module fifo_rd_stream #(
    parameter int WIDTH     = 16,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                           rd_clk,
    input  logic                           rd_rst,
    input  logic                           fifo_empty,
    input  logic [WIDTH-1:0]               fifo_data,
    output logic                           fifo_rd_en,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [WIDTH-1:0]               m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]           xfer_cnt,
    output logic [CNT_WIDTH-1:0]           stall_cnt
`endif
);

    localparam int PW  = $clog2(BUF_DEPTH);
    localparam int LW  = $clog2(BUF_DEPTH + 1);
    localparam int SW  = LW + 1;
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
    localparam logic [LW-1:0] FULL = LW'(BUF_DEPTH);
    localparam logic [SW-1:0] CAP  = SW'(BUF_DEPTH);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [LW-1:0]    occ;
    logic             inflight;
    logic             push;
    logic             pop;
    logic [SW-1:0]    committed;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // The in-flight word already owns a slot, so it counts against capacity.
    assign committed  = {1'b0, occ} + SW'(inflight);
    // Gated by rd_rst so no read escapes while the FIFO itself is in reset.
    assign fifo_rd_en = rd_rst && !fifo_empty && (committed < CAP);
    assign m_valid    = (occ != '0);
    assign m_data     = mem[head];
    assign level      = occ;
    assign push       = inflight;
    assign pop        = m_valid && m_ready;

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= fifo_rd_en;
            if (push) begin
                mem[tail] <= fifo_data;
                tail      <= nxt(tail);
            end
            if (pop) begin
                head <= nxt(head);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (m_valid && !m_ready) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

    push_into_full: assert property (
        @(posedge rd_clk) disable iff (!rd_rst) push |-> (occ != FULL)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream with a behavioural FIFO model.
// Directed scenarios; a negedge monitor checks stream data and protocol rules.
module tb_fifo_rd_stream;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rd_rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic [2:0]    level;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] stall_cnt;
`endif

    fifo_rd_stream #(.WIDTH(W), .BUF_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic         force_empty = 1'b0;
    logic         rd_req = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    int rd_cnt = 0, rd_rises = 0, v_cnt = 0, v_rises = 0, lvl_over1 = 0;
    logic prev_rd = 1'b0, prev_v = 1'b0, hold_prev = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        rd_req = fifo_rd_en;
        check("rd_en_while_empty", {31'b0, fifo_rd_en && fifo_empty}, 32'd0);
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && !prev_rd) rd_rises++;
        if (m_valid) v_cnt++;
        if (m_valid && !prev_v) v_rises++;
        if (level > 3'd1) lvl_over1++;
        if (hold_prev && rd_rst) begin
            check("hold_valid", {31'b0, m_valid}, 32'd1);
            check("hold_data", {16'b0, m_data}, {16'b0, prev_data});
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", {16'b0, m_data}, 32'hffff_ffff);
            end else begin
                check("stream_data", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
            end
        end
        prev_rd   = fifo_rd_en;
        prev_v    = m_valid;
        hold_prev = rd_rst && m_valid && !m_ready;
        prev_data = m_data;
    end

    task automatic upd_empty();
        fifo_empty = force_empty || (fifo_q.size() == 0);
    endtask

    // One clock: the FIFO model answers an accepted read one cycle later.
    task automatic tick();
        logic do_pop;
        @(posedge clk);
        do_pop = rd_req;
        #1;
        if (do_pop && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        upd_empty();
    endtask

    task automatic load(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        upd_empty();
    endtask

    task automatic wait_drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        check("drain_timeout", {31'b0, k >= budget}, 32'd0);
        repeat (3) tick();
    endtask

    int b_rd, b_rdr, b_v, b_vr, b_l;

    task automatic snap();
        b_rd = rd_cnt; b_rdr = rd_rises; b_v = v_cnt; b_vr = v_rises; b_l = lvl_over1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with a non-empty FIFO
        fifo_q.push_back(16'hdead);
        fifo_q.push_back(16'hbeef);
        upd_empty();
        repeat (3) tick();
        #3;
        check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("rst_valid", {31'b0, m_valid}, 32'd0);
        check("rst_data", {16'b0, m_data}, 32'd0);
        check("rst_level", {29'b0, level}, 32'd0);
        fifo_q.delete();
        upd_empty();
        rd_rst = 1'b1;
        repeat (2) tick();
        #3;
        check("post_rst_valid", {31'b0, m_valid}, 32'd0);
        check("post_rst_level", {29'b0, level}, 32'd0);

        // Streaming at full rate
        m_ready = 1'b1;
        snap();
        for (int i = 1; i <= 8; i++) load(W'(i));
        wait_drain(40);
        check("t2_reads", rd_cnt - b_rd, 8);
        check("t2_read_runs", rd_rises - b_rdr, 1);
        check("t2_valid_cycles", v_cnt - b_v, 8);
        check("t2_valid_runs", v_rises - b_vr, 1);
        check("t2_level_gt1", lvl_over1 - b_l, 0);

        // Back-pressure fills the buffer, then drains without a gap
        m_ready = 1'b0;
        snap();
        for (int i = 1; i <= 10; i++) load(W'(i));
        repeat (10) tick();
        #3;
        check("t3_reads", rd_cnt - b_rd, 4);
        check("t3_level", {29'b0, level}, 32'd4);
        check("t3_valid", {31'b0, m_valid}, 32'd1);
        check("t3_head", {16'b0, m_data}, 32'h0001);
        snap();
        m_ready = 1'b1;
        wait_drain(40);
        check("t3_valid_cycles", v_cnt - b_v, 10);
        check("t3_valid_runs", v_rises - b_vr, 0);

        // FIFO empty flag toggling every cycle
        snap();
        for (int i = 0; i < 6; i++) load(16'h00a1 + W'(i));
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            tick();
            force_empty = ~force_empty;
            upd_empty();
        end
        force_empty = 1'b0;
        upd_empty();
        repeat (3) tick();
        check("t4_left", exp_q.size(), 0);
        check("t4_reads", rd_cnt - b_rd, 6);
        check("t4_valid_runs", v_rises - b_vr, 6);

        // Reset in the middle of a fill: level 3 with one word in flight
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) load(16'h0c00 + W'(i));
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                tick();
                #3;
                if (level == 3'd3) break;
            end
            check("t5_reach_level3", {31'b0, k >= 20}, 32'd0);
        end
        rd_rst = 1'b0;
        #1;
        check("t5_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("t5_valid", {31'b0, m_valid}, 32'd0);
        check("t5_data", {16'b0, m_data}, 32'd0);
        check("t5_level", {29'b0, level}, 32'd0);
        fifo_q.delete();
        exp_q.delete();
        upd_empty();
        repeat (2) tick();
        rd_rst = 1'b1;
        m_ready = 1'b1;
        snap();
        repeat (8) tick();
        check("t5_no_stale", v_cnt - b_v, 0);
        check("t5_level_after", {29'b0, level}, 32'd0);

        // Handshake and stall accounting
        rd_rst = 1'b0;
        m_ready = 1'b0;
        tick();
        rd_rst = 1'b1;
`ifdef FIFO_RD_STREAM_CNT_EN
        #1;
        check("cnt_rst_xfer", {29'b0, xfer_cnt}, 32'd0);
        check("cnt_rst_stall", {29'b0, stall_cnt}, 32'd0);
`endif
        for (int i = 0; i < 9; i++) load(16'h0031 + W'(i));
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                tick();
                #3;
                if (m_valid) break;
            end
            check("t6_first_valid", {31'b0, k >= 20}, 32'd0);
        end
        tick();
        tick();
        m_ready = 1'b1;
        wait_drain(40);
        check("t6_level", {29'b0, level}, 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("cnt_xfer_wrap", {29'b0, xfer_cnt}, 32'd1);
        check("cnt_stall", {29'b0, stall_cnt}, 32'd2);
`endif
        check("final_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
